// File: rtl/systolic_ctrl_pkg.sv
// systolic_ctrl_pkg: shared array sizes, reduction limits and sequencer state encoding
package systolic_ctrl_pkg;
  localparam int MATRIX_A_ROW = 3;
  localparam int MATRIX_B_COL = 4;
  localparam int DATA_WIDTH = 8;
  localparam int K_MAX = 256;
  localparam int PE_LATENCY = 1;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} ctrl_state_e;
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: valid/data shift line of DEPTH stages (stage 0 is the caller's register), shifts on en_i
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);
  if (DEPTH < 2) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_i, en_i};
    assign valid_o = valid_i;
    assign data_o = data_i;
  end else begin : g_regs
    logic [DEPTH-2:0] vld;
    logic [DEPTH-2:0][DW-1:0] dat;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld <= '0;
        dat <= '0;
      end else if (en_i) begin
        vld <= (DEPTH-1)'({vld, valid_i});
        dat <= ((DEPTH-1)*DW)'({dat, data_i});
      end
    end
    assign valid_o = vld[DEPTH-2];
    assign data_o = dat[DEPTH-2];
  end
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: start/k_len in, A/B buffer reads out, skewed west/north valid/data lanes under ready, acc_clear/busy/done
module systolic_ctrl #(
  parameter int ROWS = systolic_ctrl_pkg::MATRIX_A_ROW,
  parameter int COLS = systolic_ctrl_pkg::MATRIX_B_COL,
  parameter int DW = systolic_ctrl_pkg::DATA_WIDTH,
  parameter int K_MAX = systolic_ctrl_pkg::K_MAX,
  parameter int PE_LATENCY = systolic_ctrl_pkg::PE_LATENCY,
  localparam int KW = $clog2(K_MAX + 1),
  localparam int AW = $clog2(K_MAX)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [KW-1:0]        k_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 acc_clear_o,
  output logic                 a_rd_en_o,
  output logic [AW-1:0]        a_rd_addr_o,
  input  logic [ROWS*DW-1:0]   a_rd_data_i,
  output logic                 b_rd_en_o,
  output logic [AW-1:0]        b_rd_addr_o,
  input  logic [COLS*DW-1:0]   b_rd_data_i,
  output logic [ROWS-1:0]      west_valid_o,
  input  logic [ROWS-1:0]      west_ready_i,
  output logic [ROWS*DW-1:0]   west_data_o,
  output logic [COLS-1:0]      north_valid_o,
  input  logic [COLS-1:0]      north_ready_i,
  output logic [COLS*DW-1:0]   north_data_o
);
  import systolic_ctrl_pkg::*;
  localparam int M = ROWS > COLS ? ROWS : COLS;
  localparam int DRAIN_CYC = (ROWS < COLS ? ROWS : COLS) - 1 + PE_LATENCY;
  localparam int CW = KW + 1;
  ctrl_state_e state, state_n;
  logic [KW-1:0] k_len;
  logic [CW-1:0] cnt;
  logic rd_vld, adv, rd_en, feed_last, drain_last;
  logic [ROWS-1:0] w_vld;
  logic [COLS-1:0] n_vld;
  logic [ROWS-1:0][DW-1:0] w_dat;
  logic [COLS-1:0][DW-1:0] n_dat;
  // FEED runs one beat longer than the output window: beat 0 only issues the first read
  always_comb begin
    adv = ~|(w_vld & ~west_ready_i) & ~|(n_vld & ~north_ready_i);
    rd_en = state == FEED && adv && cnt < {1'b0, k_len};
    feed_last = cnt == {1'b0, k_len} + CW'(M - 1);
    drain_last = cnt == CW'(DRAIN_CYC - 1);
    state_n = state == IDLE ? (start_i ? CLEAR : IDLE)
            : state == CLEAR ? (k_len == '0 ? DONE : FEED)
            : state == FEED ? (adv && feed_last ? DRAIN : FEED)
            : state == DRAIN ? (drain_last ? DONE : DRAIN)
            : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      k_len <= '0;
      cnt <= '0;
      rd_vld <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start_i) k_len <= k_len_i;
      cnt <= state != state_n ? '0 : (state == FEED && adv) || state == DRAIN ? cnt + CW'(1) : cnt;
      if (adv) rd_vld <= rd_en;
    end
  end
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign acc_clear_o = state == CLEAR;
  assign a_rd_en_o = rd_en;
  assign b_rd_en_o = rd_en;
  assign a_rd_addr_o = cnt[AW-1:0];
  assign b_rd_addr_o = cnt[AW-1:0];
  assign west_valid_o = w_vld;
  assign north_valid_o = n_vld;
  // The buffer's held output register plus rd_vld form stage 0 of every lane
  for (genvar r = 0; r < ROWS; r++) begin : g_west
    skew_delay_line #(.DEPTH(r + 1), .DW(DW)) u_line (
      .clk_i, .rst_i, .en_i(adv), .valid_i(rd_vld), .data_i(a_rd_data_i[r*DW +: DW]),
      .valid_o(w_vld[r]), .data_o(w_dat[r])
    );
    assign west_data_o[r*DW +: DW] = w_vld[r] ? w_dat[r] : '0;
  end
  for (genvar c = 0; c < COLS; c++) begin : g_north
    skew_delay_line #(.DEPTH(c + 1), .DW(DW)) u_line (
      .clk_i, .rst_i, .en_i(adv), .valid_i(rd_vld), .data_i(b_rd_data_i[c*DW +: DW]),
      .valid_o(n_vld[c]), .data_o(n_dat[c])
    );
    assign north_data_o[c*DW +: DW] = n_vld[c] ? n_dat[c] : '0;
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: table-driven runs plus restart and reset sequences against systolic_ctrl
module tb_systolic_ctrl;
  import systolic_ctrl_pkg::*;
  localparam int ROWS = MATRIX_A_ROW;
  localparam int COLS = MATRIX_B_COL;
  localparam int DW = DATA_WIDTH;
  localparam int KW = $clog2(K_MAX + 1);
  localparam int AW = $clog2(K_MAX);
  localparam int M = ROWS > COLS ? ROWS : COLS;
  localparam int DRAIN_CYC = (ROWS < COLS ? ROWS : COLS) - 1 + PE_LATENCY;
  // start->done cycles without stalls for k_len=k > 0: 2 + k + M-1 + DRAIN_CYC + 1
  localparam int BASE_CYC = 2 + M - 1 + DRAIN_CYC + 1;
  typedef struct {
    int k;
    int pat;
    int stall;
    int exp_cyc;
    int exp_pe00;
  } vec_t;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic [KW-1:0] k_len_i = '0;
  logic busy_o, done_o, acc_clear_o, a_rd_en_o, b_rd_en_o;
  logic [AW-1:0] a_rd_addr_o, b_rd_addr_o;
  logic [ROWS*DW-1:0] a_rd_data_i;
  logic [COLS*DW-1:0] b_rd_data_i;
  logic [ROWS-1:0] west_valid_o;
  logic [ROWS-1:0] west_ready_i = '1;
  logic [ROWS*DW-1:0] west_data_o;
  logic [COLS-1:0] north_valid_o;
  logic [COLS-1:0] north_ready_i = '1;
  logic [COLS*DW-1:0] north_data_o;
  int A[ROWS][K_MAX];
  int B[K_MAX][COLS];
  int wseq[ROWS][$];
  int nseq[COLS][$];
  int vecs = 0, errs = 0, ob = -100, cur_k = 0, clr_cnt = 0, rd_cnt = 0;
  vec_t tbl[6];

  systolic_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i),
    .busy_o(busy_o), .done_o(done_o), .acc_clear_o(acc_clear_o),
    .a_rd_en_o(a_rd_en_o), .a_rd_addr_o(a_rd_addr_o), .a_rd_data_i(a_rd_data_i),
    .b_rd_en_o(b_rd_en_o), .b_rd_addr_o(b_rd_addr_o), .b_rd_data_i(b_rd_data_i),
    .west_valid_o(west_valid_o), .west_ready_i(west_ready_i), .west_data_o(west_data_o),
    .north_valid_o(north_valid_o), .north_ready_i(north_ready_i), .north_data_o(north_data_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_rd_en_o) for (int r = 0; r < ROWS; r++) a_rd_data_i[r*DW +: DW] <= DW'(A[r][a_rd_addr_o]);
    if (b_rd_en_o) for (int c = 0; c < COLS; c++) b_rd_data_i[c*DW +: DW] <= DW'(B[b_rd_addr_o][c]);
  end

  function automatic void chk(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ob is the output beat of the current cycle: -1 in the first FEED cycle, then advances on adv
  always @(negedge clk) begin
    bit adv_b, exp_v;
    adv_b = ~|(west_valid_o & ~west_ready_i) & ~|(north_valid_o & ~north_ready_i);
    for (int r = 0; r < ROWS; r++) begin
      exp_v = ob >= r && ob < r + cur_k;
      chk($sformatf("west_valid[%0d] beat %0d", r, ob), int'(west_valid_o[r]), int'(exp_v));
      if (exp_v) chk($sformatf("west_data[%0d] beat %0d", r, ob), int'($signed(west_data_o[r*DW +: DW])), A[r][ob-r]);
      if (west_valid_o[r] && adv_b) wseq[r].push_back(int'($signed(west_data_o[r*DW +: DW])));
    end
    for (int c = 0; c < COLS; c++) begin
      exp_v = ob >= c && ob < c + cur_k;
      chk($sformatf("north_valid[%0d] beat %0d", c, ob), int'(north_valid_o[c]), int'(exp_v));
      if (exp_v) chk($sformatf("north_data[%0d] beat %0d", c, ob), int'($signed(north_data_o[c*DW +: DW])), B[ob-c][c]);
      if (north_valid_o[c] && adv_b) nseq[c].push_back(int'($signed(north_data_o[c*DW +: DW])));
    end
    if (a_rd_en_o || b_rd_en_o) begin
      chk("b_rd_en", int'(b_rd_en_o), int'(a_rd_en_o));
      chk("a_rd_addr", int'(a_rd_addr_o), rd_cnt);
      chk("b_rd_addr", int'(b_rd_addr_o), rd_cnt);
      rd_cnt++;
    end
    if (acc_clear_o) begin
      clr_cnt++;
      rd_cnt = 0;
      for (int r = 0; r < ROWS; r++) wseq[r].delete();
      for (int c = 0; c < COLS; c++) nseq[c].delete();
    end
    ob = rst_i ? -100 : acc_clear_o ? -1 : done_o ? -100 : (adv_b && ob >= -1) ? ob + 1 : ob;
  end

  task automatic fill(input int pat);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < K_MAX; k++)
        A[r][k] = pat == 0 ? (r == 0 && k == 0 ? 2 : r == 0 && k == 1 ? -4 : 0)
                : pat == 1 ? int'(r == k) : pat == 2 ? r - k : 1;
    for (int k = 0; k < K_MAX; k++)
      for (int c = 0; c < COLS; c++)
        B[k][c] = pat == 0 ? (c == 0 && k == 0 ? -3 : c == 0 && k == 1 ? 5 : 0)
                : pat == 1 ? (k < ROWS ? k * COLS + c : 0) : pat == 2 ? k + c - 2 : (k & 7) - 3;
  endtask

  // Cycle 0 is the start cycle; returns the cycle index in which done_o is seen
  task automatic run(input int k, input int stall, input int rst_cyc, input bit repulse, output int cyc);
    bit seen = 0;
    clr_cnt = 0;
    cur_k = k;
    k_len_i = KW'(k);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    while (!seen && cyc < 1000 && !(rst_cyc > 0 && cyc > rst_cyc)) begin
      west_ready_i = (cyc >= 5 && cyc < 5 + stall) ? ~(ROWS'(1) << 1) : '1;
      start_i = repulse && (cyc == 4 || cyc == k + M + 2);
      k_len_i = repulse ? KW'(7) : KW'(k);
      rst_i = rst_cyc > 0 && cyc == rst_cyc;
      @(negedge clk);
      if (done_o) seen = 1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    rst_i = 1'b0;
    start_i = 1'b0;
    west_ready_i = '1;
    if (rst_cyc == 0) chk("done_seen", int'(seen), 1);
  endtask

  // Called at the negedge of the done_o cycle
  task automatic post(input int cyc, input int exp_cyc, input int exp_pe00, input int k);
    int res, mdl;
    chk("cycles", cyc, exp_cyc);
    chk("busy_in_done", int'(busy_o), 1);
    chk("clear_pulses", clr_cnt, 1);
    chk("rd_count", rd_cnt, k);
    for (int r = 0; r < ROWS; r++) chk($sformatf("west_count[%0d]", r), wseq[r].size(), k);
    for (int c = 0; c < COLS; c++) chk($sformatf("north_count[%0d]", c), nseq[c].size(), k);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        res = 0;
        mdl = 0;
        for (int j = 0; j < wseq[r].size() && j < nseq[c].size(); j++) res += wseq[r][j] * nseq[c][j];
        for (int j = 0; j < k; j++) mdl += A[r][j] * B[j][c];
        chk($sformatf("result[%0d][%0d]", r, c), res, mdl);
        if (r == 0 && c == 0) chk("pe00", res, exp_pe00);
      end
    @(negedge clk);
    chk("done_width", int'(done_o), 0);
    chk("busy_after_done", int'(busy_o), 0);
  endtask

  initial begin
    int cyc, extra;
    tbl[0] = '{2, 0, 0, 11, -26};
    tbl[1] = '{3, 1, 0, 12, 0};
    tbl[2] = '{3, 1, 3, 15, 0};
    tbl[3] = '{0, 1, 0, 2, 0};
    tbl[4] = '{4, 2, 0, 13, -2};
    tbl[5] = '{256, 3, 0, 265, 128};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_clear", int'(acc_clear_o), 0);
    chk("rst_rd_en", int'({a_rd_en_o, b_rd_en_o}), 0);
    chk("rst_addr", int'({a_rd_addr_o, b_rd_addr_o}), 0);
    chk("rst_west", int'(|{west_valid_o, west_data_o}), 0);
    chk("rst_north", int'(|{north_valid_o, north_data_o}), 0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fill(tbl[i].pat);
      run(tbl[i].k, tbl[i].stall, 0, 0, cyc);
      post(cyc, tbl[i].exp_cyc, tbl[i].exp_pe00, tbl[i].k);
      @(posedge clk);
      #1;
    end
    fill(0);
    run(2, 0, 0, 1, cyc);
    post(cyc, BASE_CYC + 2, -26, 2);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      extra += int'(done_o);
    end
    chk("extra_done", extra, 0);
    @(posedge clk);
    #1;
    fill(1);
    run(3, 0, 6, 0, cyc);
    @(negedge clk);
    chk("post_rst_west", int'(west_valid_o), 0);
    chk("post_rst_north", int'(north_valid_o), 0);
    chk("post_rst_busy", int'(busy_o), 0);
    @(posedge clk);
    #1;
    fill(0);
    run(1, 0, 0, 0, cyc);
    post(cyc, BASE_CYC + 1, -6, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
